// File: rtl/distance_loader_if.sv
// Stream-in / table-write-out bundle for the distance loader.
// Latency: none (wires only).
// Backpressure: s_ready from the loader stalls the upstream word stream.
interface distance_loader_if #(
    parameter int CITY_LOG = 5,
    parameter int DIST_W   = 16
);
    logic                  s_valid;
    logic [DIST_W-1:0]     s_data;
    logic                  s_ready;
    logic                  distance_write;
    logic [2*CITY_LOG-1:0] distance_w_addr;
    logic [DIST_W-1:0]     distance_w_data;

    // Host side: produces stream words, observes the table write port.
    modport master (
        output s_valid, s_data,
        input  s_ready, distance_write, distance_w_addr, distance_w_data
    );

    // Loader side: consumes stream words, drives the table write port.
    modport slave (
        input  s_valid, s_data,
        output s_ready, distance_write, distance_w_addr, distance_w_data
    );
endinterface

// File: rtl/distance_loader.sv
// Expands an upper-triangle distance stream into full NxN table writes (mirror + zero diagonal).
// Latency: first write 2 cycles after start; N*N back-to-back writes when the stream never stalls.
// Backpressure: s_ready only in FWD, so at most one word per 2 cycles; writes never stall.
module distance_loader #(
    parameter int CITY_NUM = 32,
    parameter int CITY_LOG = 5,
    parameter int DIST_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CITY_LOG:0] cfg_city_num,
    output logic              busy,
    output logic              done,
    output logic              err,
    distance_loader_if.slave  dl
);
    typedef enum logic [2:0] {IDLE, ZERO, FWD, MIRROR, DONE} state_t;

    localparam logic [CITY_LOG:0]   N_MIN = 2;
    localparam logic [CITY_LOG:0]   N_MAX = CITY_NUM;
    localparam logic [CITY_LOG:0]   ONE_N = 1;
    localparam logic [CITY_LOG-1:0] ONE_I = 1;

    state_t              state_q, state_nxt;
    logic [CITY_LOG-1:0] i_q, j_q, i_nxt, j_nxt;
    logic [CITY_LOG:0]   n_q, n_last;
    logic [DIST_W-1:0]   hold_q;
    logic                hold_ld, n_ld, err_nxt, cfg_ok;
    logic                i_last, j_more;

    logic                wr_vld;
    logic [CITY_LOG-1:0] wr_row, wr_col;
    logic [DIST_W-1:0]   wr_dat;

    logic                  wr_q;
    logic [2*CITY_LOG-1:0] addr_q;
    logic [DIST_W-1:0]     data_q;

    assign cfg_ok = (cfg_city_num >= N_MIN) && (cfg_city_num <= N_MAX);
    assign n_last = n_q - ONE_N;
    assign i_last = ({1'b0, i_q} == n_last);
    assign j_more = ({1'b0, j_q} < n_last);

    // Next-state, counter updates and the write issued this cycle.
    always_comb begin
        state_nxt = state_q;
        i_nxt     = i_q;
        j_nxt     = j_q;
        n_ld      = 1'b0;
        hold_ld   = 1'b0;
        err_nxt   = 1'b0;
        wr_vld    = 1'b0;
        wr_row    = '0;
        wr_col    = '0;
        wr_dat    = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        n_ld      = 1'b1;
                        i_nxt     = '0;
                        state_nxt = ZERO;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ZERO: begin
                wr_vld = 1'b1;
                wr_row = i_q;
                wr_col = i_q;
                if (i_last) begin
                    state_nxt = DONE;
                end else begin
                    j_nxt     = i_q + ONE_I;
                    state_nxt = FWD;
                end
            end
            FWD: begin
                if (dl.s_valid) begin
                    wr_vld    = 1'b1;
                    wr_row    = i_q;
                    wr_col    = j_q;
                    wr_dat    = dl.s_data;
                    hold_ld   = 1'b1;
                    state_nxt = MIRROR;
                end
            end
            MIRROR: begin
                wr_vld = 1'b1;
                wr_row = j_q;
                wr_col = i_q;
                wr_dat = hold_q;
                if (j_more) begin
                    j_nxt     = j_q + ONE_I;
                    state_nxt = FWD;
                end else begin
                    i_nxt     = i_q + ONE_I;
                    state_nxt = ZERO;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort only redirects the FSM; a write decided this cycle still goes out.
        if (abort && (state_q != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Row/column counters, latched city count and the word waiting to be mirrored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q    <= '0;
            j_q    <= '0;
            n_q    <= '0;
            hold_q <= '0;
        end else begin
            i_q <= i_nxt;
            j_q <= j_nxt;
            if (n_ld) begin
                n_q <= cfg_city_num;
            end
            if (hold_ld) begin
                hold_q <= dl.s_data;
            end
        end
    end

    // Registered write port and status pulses; address/data hold between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            wr_q <= wr_vld;
            if (wr_vld) begin
                addr_q <= {wr_row, wr_col};
                data_q <= wr_dat;
            end
            done <= (state_q == DONE) && !abort;
            err  <= err_nxt;
        end
    end

    assign busy               = (state_q != IDLE);
    assign dl.s_ready         = (state_q == FWD);
    assign dl.distance_write  = wr_q;
    assign dl.distance_w_addr = addr_q;
    assign dl.distance_w_data = data_q;
endmodule

// File: doc/distance_loader.md
Name: distance_loader

Overview:
- Upstream feeder for the replica array's distance-table write port (distance_write / distance_w_addr / distance_w_data).
- Accepts the upper triangle of a symmetric city-distance matrix as a valid/ready word stream.
- Expands it into the full N×N table: mirrors every off-diagonal word and inserts zero diagonal entries, one table write per cycle.
- Lets the host load a new problem with N(N-1)/2 transfers instead of N².

Parameters:
- CITY_NUM, 32: maximum supported city count.
- CITY_LOG, 5: bits per city index; must satisfy 2^CITY_LOG ≥ CITY_NUM. Bound to city_num_log at instantiation.
- DIST_W, 16: distance word width. Bound to $bits(distance_data_t) at instantiation.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  load request; sampled only in IDLE
- abort  in  1  synchronous cancel of a running load
- cfg_city_num  in  CITY_LOG+1  city count N; latched when start is accepted
- s_valid  in  1  stream word valid
- s_data  in  DIST_W  stream word (upper-triangle distance)
- s_ready  out  1  stream word accepted when s_valid && s_ready
- busy  out  1  load in progress
- done  out  1  one-cycle pulse: load completed
- err  out  1  one-cycle pulse: start rejected
- distance_write  out  1  table write strobe
- distance_w_addr  out  2*CITY_LOG  {row, col}; row in the upper CITY_LOG bits
- distance_w_data  out  DIST_W  table write data

Behaviour:
- Reset (reset low, asynchronous): every output is 0, state IDLE, counters i=j=0. Deassertion mid-load discards the load; no done.
- Stream order: row-major upper triangle: (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1).
- FSM states: IDLE, ZERO, FWD, MIRROR, DONE.
- IDLE: s_ready=0. On start:
  - If 2 ≤ cfg_city_num ≤ CITY_NUM: latch N, set i=0, go to ZERO.
  - Otherwise: err=1 next cycle, stay IDLE, no writes.
- ZERO: issue write (i,i)=0.
  - If i==N-1, go to DONE.
  - Otherwise set j=i+1 and go to FWD.
- FWD: s_ready=1. On handshake, issue write (i,j)=s_data, hold the word, go to MIRROR. Without handshake, stall in FWD; no timeout.
- MIRROR: s_ready=0. Issue write (j,i)=held word.
  - If j<N-1: j++, go to FWD.
  - Else: i++, go to ZERO.
- DONE: go to IDLE; done pulses one cycle later (registered).
- Write outputs are registered: a write issued in cycle c is visible on the ports in cycle c+1. distance_write is high for exactly one cycle per write. Address and data hold their last value when no write is issued.
- busy = (state != IDLE), decoded from the state register.
- Timing: start high in cycle t with a valid N and s_valid held high:
  - distance_write is high in cycles t+2 … t+1+N² (N² back-to-back writes).
  - busy is high t+1 … t+1+N².
  - done is high in cycle t+2+N².
- Throughput: at most one stream word per 2 cycles (the MIRROR cycle backpressures).
- start while busy: ignored, no err. start and abort together in IDLE: start wins.
- abort while busy: next state IDLE; any write already issued still appears; no further writes; no done; s_ready drops the next cycle. Any stream words not yet accepted stay with the producer.
- s_valid while idle: s_ready=0; the word is neither consumed nor written.
- cfg_city_num changing during a load has no effect.
- Table entries outside N×N are never written.

Test Plan:
- N=3, stream 5,7,9 with s_valid held high, CITY_LOG=5:
  - Writes, in order: (0,0)=0 @0x000, (0,1)=5 @0x001, (1,0)=5 @0x020, (0,2)=7 @0x002, (2,0)=7 @0x040, (1,1)=0 @0x021, (1,2)=9 @0x022, (2,1)=9 @0x041, (2,2)=0 @0x042.
  - Writes occupy cycles t+2..t+10; done at t+11; busy falls at t+11.
- N=2, one word 0x00FF; s_valid low for 3 cycles in FWD before asserting:
  - Writes (0,0)=0, (0,1)=0xFF, (1,0)=0xFF, (1,1)=0.
  - s_ready stays high through the stall; distance_write stays low during the stall.
- cfg_city_num=1, then 33 (CITY_NUM=32): each start gives an err pulse the next cycle; busy, s_ready and distance_write stay 0.
- N=32 full load of 496 words with random s_valid gaps:
  - Scoreboard the table: T[r][c]==T[c][r], diagonal all 0, exactly 1024 writes, one done.
- N=4, abort asserted after the 2nd handshake:
  - At most 1 write after the abort cycle; busy=0 two cycles later; no done.
  - A fresh start then completes all 16 writes correctly.
- reset pulled low mid-MIRROR: all outputs 0 immediately (asynchronous); after release the block is IDLE and accepts start normally.
